// File: rtl/nibble_loader_pkg.sv
// Shared types and constants for the nibble loader.
package nibble_loader_pkg;
  localparam int NIB_W       = 4;
  localparam int ERR_PARITY  = 0;
  localparam int ERR_TIMEOUT = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    LOAD   = 2'd3
  } state_t;
endpackage

// File: rtl/nl_idle_timer.sv
// Idle-cycle counter for the nibble loader; expire pulses on the TIMEOUT-th idle cycle.
module nl_idle_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic kick,
  output logic expire
);
  localparam logic [7:0] LIMIT = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  // expire is decoded during the last idle cycle so the caller acts on that edge
  always_comb begin
    expire = (TIMEOUT != 0) && run && !kick && (cnt_q == LIMIT);
    if (!run || kick || expire || (TIMEOUT == 0))
      cnt_d = '0;
    else
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/nibble_loader.sv
// Serial-to-nibble loader feeding a 4-bit enable register.
// Optional even-parity bit per nibble: define NIBBLE_LOADER_PARITY_EN.
module nibble_loader
  import nibble_loader_pkg::*;
#(
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT   = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_bit,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             err_clr,
  output logic [NIB_W-1:0] d,
  output logic             en,
  output logic             busy,
  output logic [1:0]       err,
  output logic [7:0]       nib_count
);
  state_t           state_q;
  logic [NIB_W-1:0] shift_q, shift_d, d_q;
  logic [1:0]       idx_q;
  logic             en_q, busy_q;
  logic [1:0]       err_q, err_set;
  logic [7:0]       cnt_q;
  logic             accept, run, expire;

  assign s_ready   = !reset && (state_q != LOAD);
  assign accept    = s_valid && s_ready;
  assign run       = (state_q == SHIFT) || (state_q == PARITY);
  assign d         = d_q;
  assign en        = en_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign nib_count = cnt_q;

  nl_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .kick  (accept),
    .expire(expire)
  );

  always_comb begin
    shift_d = (MSB_FIRST != 0) ? {shift_q[NIB_W-2:0], s_bit} : {s_bit, shift_q[NIB_W-1:1]};
    err_set = '0;
    if (expire) err_set[ERR_TIMEOUT] = 1'b1;
`ifdef NIBBLE_LOADER_PARITY_EN
    if ((state_q == PARITY) && accept && ((^shift_q) ^ s_bit)) err_set[ERR_PARITY] = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      d_q     <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      en_q  <= 1'b0;
      err_q <= (err_q & ~{2{err_clr}}) | err_set;
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q <= shift_d;
            idx_q   <= 2'd1;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (expire) begin
            shift_q <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (accept) begin
            shift_q <= shift_d;
            idx_q   <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
`ifdef NIBBLE_LOADER_PARITY_EN
              state_q <= PARITY;
`else
              d_q     <= shift_d;
              en_q    <= 1'b1;
              busy_q  <= 1'b0;
              cnt_q   <= cnt_q + 8'd1;
              state_q <= LOAD;
`endif
            end
          end
        end
`ifdef NIBBLE_LOADER_PARITY_EN
        PARITY: begin
          if (expire) begin
            shift_q <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (accept) begin
            idx_q  <= '0;
            busy_q <= 1'b0;
            if (((^shift_q) ^ s_bit) == 1'b0) begin
              d_q     <= shift_q;
              en_q    <= 1'b1;
              cnt_q   <= cnt_q + 8'd1;
              state_q <= LOAD;
            end else begin
              shift_q <= '0;
              state_q <= IDLE;
            end
          end
        end
`endif
        LOAD:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_loader.sv
// Directed bench: an MSB-first and an LSB-first loader driven by the same stream.
module tb_nibble_loader;
  logic       clk = 1'b0;
  logic       reset, s_bit, s_valid, err_clr;
  logic       rdy_m, en_m, busy_m, rdy_l, en_l, busy_l;
  logic [3:0] d_m, d_l;
  logic [1:0] err_m, err_l;
  logic [7:0] cnt_m, cnt_l;

  int n_checks = 0;
  int n_pass   = 0;
  int en_seen  = 0;
  int en_double = 0;
  logic en_prev = 1'b0;
  int e0, d0;

`ifdef NIBBLE_LOADER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  always #5 clk = ~clk;

  nibble_loader #(.MSB_FIRST(1), .TIMEOUT(15)) u_msb (
    .clk(clk), .reset(reset), .s_bit(s_bit), .s_valid(s_valid), .s_ready(rdy_m),
    .err_clr(err_clr), .d(d_m), .en(en_m), .busy(busy_m), .err(err_m), .nib_count(cnt_m)
  );

  nibble_loader #(.MSB_FIRST(0), .TIMEOUT(15)) u_lsb (
    .clk(clk), .reset(reset), .s_bit(s_bit), .s_valid(s_valid), .s_ready(rdy_l),
    .err_clr(err_clr), .d(d_l), .en(en_l), .busy(busy_l), .err(err_l), .nib_count(cnt_l)
  );

  always @(negedge clk) begin
    if (en_m) en_seen = en_seen + 1;
    if (en_m && en_prev) en_double = en_double + 1;
    en_prev = en_m;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
  endtask

  // data bits go out b[3] first; p is the parity bit when that build option is on
  task automatic send(input logic [3:0] b, input logic p);
    for (int i = 3; i >= 0; i--) begin
      s_valid = 1'b1;
      s_bit   = b[i];
      tick();
    end
    if (PAR != 0) begin
      s_valid = 1'b1;
      s_bit   = p;
      tick();
    end
    s_valid = 1'b0;
    s_bit   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; s_bit = 1'b0; s_valid = 1'b1; err_clr = 1'b0;
    repeat (2) tick();
    check("rst_ready_m", rdy_m, 0);
    check("rst_ready_l", rdy_l, 0);
    check("rst_d", d_m, 0);
    check("rst_en", en_m, 0);
    check("rst_busy", busy_m, 0);
    check("rst_err", err_m, 0);
    check("rst_cnt", cnt_m, 0);
    s_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("idle_ready", rdy_m, 1);

    // first nibble 1,0,1,1
    e0 = en_seen;
    send(4'b1011, 1'b1);
    check("n1_en", en_m, 1);
    check("n1_d_msb", d_m, 4'b1011);
    check("n1_d_lsb", d_l, 4'b1101);
    check("n1_ready_low", rdy_m, 0);
    check("n1_busy_low", busy_m, 0);
    tick();
    check("n1_en_off", en_m, 0);
    check("n1_cnt", cnt_m, 1);
    check("n1_d_hold", d_m, 4'b1011);
    check("n1_one_pulse", 8'(en_seen - e0), 1);

    // two bits then 15 idle cycles
    e0 = en_seen;
    s_valid = 1'b1; s_bit = 1'b1;
    tick(); tick();
    s_valid = 1'b0;
    check("to_busy", busy_m, 1);
    repeat (14) tick();
    check("to_busy_14", busy_m, 1);
    check("to_err_14", err_m, 0);
    tick();
    check("to_busy_15", busy_m, 0);
    check("to_err_15", err_m, 2'b10);
    check("to_d_hold", d_m, 4'b1011);
    check("to_cnt_hold", cnt_m, 1);
    check("to_no_en", 8'(en_seen - e0), 0);
    send(4'b1000, 1'b1);
    check("n2_en", en_m, 1);
    check("n2_d_msb", d_m, 4'b1000);
    check("n2_d_lsb", d_l, 4'b0001);
    tick();
    check("n2_cnt", cnt_m, 2);
    check("n2_err_sticky", err_m, 2'b10);

    // err_clr alone, then err_clr colliding with a timeout set
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_alone", err_m, 0);
    s_valid = 1'b1; s_bit = 1'b0;
    tick();
    s_valid = 1'b0;
    repeat (14) tick();
    err_clr = 1'b1;
    tick();
    check("clr_set_wins", err_m, 2'b10);
    check("clr_set_busy", busy_m, 0);
    tick();
    err_clr = 1'b0;
    check("clr_next", err_m, 0);

    // reset after three bits
    s_valid = 1'b1; s_bit = 1'b1;
    repeat (3) tick();
    check("mid_busy", busy_m, 1);
    e0 = en_seen;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy_m, 0);
    check("mid_rst_ready", rdy_m, 0);
    check("mid_rst_d", d_m, 0);
    check("mid_rst_cnt", cnt_m, 0);
    s_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("mid_rst_no_en", 8'(en_seen - e0), 0);
    send(4'b0110, 1'b0);
    check("n3_en", en_m, 1);
    check("n3_d_msb", d_m, 4'b0110);
    check("n3_d_lsb", d_l, 4'b0110);
    tick();
    check("n3_cnt", cnt_m, 1);

    // back-to-back with s_valid held high for 20 edges
    e0 = en_seen; d0 = en_double;
    s_valid = 1'b1; s_bit = 1'b0;
    repeat (20) tick();
    s_valid = 1'b0;
    check("rate_pulses", 8'(en_seen - e0), (PAR != 0) ? 3 : 4);
    check("rate_single", 8'(en_double - d0), 0);
    check("rate_cnt", cnt_m, (PAR != 0) ? 4 : 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // nibble counter wrap
    repeat (255) begin
      send(4'b0101, 1'b0);
      tick();
    end
    check("wrap_255", cnt_m, 255);
    send(4'b0101, 1'b0);
    tick();
    check("wrap_0", cnt_m, 0);
    check("wrap_d", d_m, 4'b0101);

`ifdef NIBBLE_LOADER_PARITY_EN
    send(4'b1011, 1'b1);
    check("par_ok_en", en_m, 1);
    check("par_ok_d", d_m, 4'b1011);
    tick();
    e0 = en_seen;
    send(4'b0011, 1'b1);
    check("par_bad_en", en_m, 0);
    check("par_bad_err", err_m, 2'b01);
    check("par_bad_d", d_m, 4'b1011);
    tick();
    check("par_bad_no_en", 8'(en_seen - e0), 0);
`else
    check("par_tied", err_m, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
